// File: rtl/axi_divider_arbiter.sv
// axi_divider_arbiter
// Two requesters share one pipelined AXI-stream divider. Issue slots are
// granted round-robin, optionally held for a whole packet. A tag FIFO
// remembers the owner of each in-flight operation so that results can be
// steered back in issue order.
module axi_divider_arbiter #(
  parameter int W        = 24,
  parameter int DEPTH    = 32,
  parameter bit PKT_LOCK = 1'b1
) (
  input  logic                       clk,
  input  logic                       aresetn,
  input  logic [W-1:0]               s0_dividend_tdata,
  input  logic [W-1:0]               s0_divisor_tdata,
  input  logic                       s0_tlast,
  input  logic                       s0_tvalid,
  output logic                       s0_tready,
  input  logic [W-1:0]               s1_dividend_tdata,
  input  logic [W-1:0]               s1_divisor_tdata,
  input  logic                       s1_tlast,
  input  logic                       s1_tvalid,
  output logic                       s1_tready,
  output logic [W-1:0]               div_dividend_tdata,
  output logic [W-1:0]               div_divisor_tdata,
  output logic                       div_tlast,
  output logic                       div_tvalid,
  input  logic                       div_tready,
  input  logic [2*W-1:0]             div_dout_tdata,
  input  logic                       div_dout_tlast,
  input  logic                       div_dout_tvalid,
  output logic                       div_dout_tready,
  output logic [2*W-1:0]             m0_tdata,
  output logic                       m0_tlast,
  output logic                       m0_tvalid,
  input  logic                       m0_tready,
  output logic [2*W-1:0]             m1_tdata,
  output logic                       m1_tlast,
  output logic                       m1_tvalid,
  input  logic                       m1_tready,
  output logic [$clog2(DEPTH):0]     inflight,
  output logic                       err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          tag_mem_r [DEPTH];
  logic          last_r;
  logic          lock_r;
  logic          lock_id_r;
  logic          err_r;

  logic          full_s;
  logic          empty_s;
  logic          gnt_valid_s;
  logic          gnt_id_s;
  logic          sel_valid_s;
  logic          sel_last_s;
  logic          push_s;
  logic          pop_s;
  logic          head_s;
  logic          head_ready_s;

  assign full_s  = (count_r == FULL_CNT);
  assign empty_s = (count_r == {(AW+1){1'b0}});

  // Grant selection: packet lock wins, otherwise alternate under contention.
  always_comb begin
    gnt_valid_s = 1'b0;
    gnt_id_s    = 1'b0;
    if (lock_r) begin
      gnt_valid_s = 1'b1;
      gnt_id_s    = lock_id_r;
    end else if (s0_tvalid && s1_tvalid) begin
      gnt_valid_s = 1'b1;
      gnt_id_s    = ~last_r;
    end else if (s0_tvalid) begin
      gnt_valid_s = 1'b1;
      gnt_id_s    = 1'b0;
    end else if (s1_tvalid) begin
      gnt_valid_s = 1'b1;
      gnt_id_s    = 1'b1;
    end else begin
      gnt_valid_s = 1'b0;
      gnt_id_s    = 1'b0;
    end
  end

  // Issue path: steer the granted requester onto the divider inputs.
  always_comb begin
    div_dividend_tdata = s0_dividend_tdata;
    div_divisor_tdata  = s0_divisor_tdata;
    sel_last_s         = s0_tlast;
    sel_valid_s        = s0_tvalid;
    if (gnt_id_s) begin
      div_dividend_tdata = s1_dividend_tdata;
      div_divisor_tdata  = s1_divisor_tdata;
      sel_last_s         = s1_tlast;
      sel_valid_s        = s1_tvalid;
    end else begin
      div_dividend_tdata = s0_dividend_tdata;
      div_divisor_tdata  = s0_divisor_tdata;
      sel_last_s         = s0_tlast;
      sel_valid_s        = s0_tvalid;
    end
  end

  // Full is taken from registered occupancy, so a same-cycle pop never frees a slot
  // and m_k_tready has no path into s_k_tready.
  assign div_tlast  = sel_last_s;
  assign div_tvalid = gnt_valid_s & sel_valid_s & ~full_s;
  assign s0_tready  = gnt_valid_s & ~gnt_id_s & div_tready & ~full_s;
  assign s1_tready  = gnt_valid_s &  gnt_id_s & div_tready & ~full_s;
  assign push_s     = div_tvalid & div_tready;

  // Return path: the FIFO head decides which requester sees the result.
  assign head_s          = tag_mem_r[rd_ptr_r];
  assign head_ready_s    = head_s ? m1_tready : m0_tready;
  assign div_dout_tready = ~empty_s & head_ready_s;
  assign m0_tvalid       = div_dout_tvalid & ~empty_s & ~head_s;
  assign m1_tvalid       = div_dout_tvalid & ~empty_s &  head_s;
  assign m0_tdata        = div_dout_tdata;
  assign m1_tdata        = div_dout_tdata;
  assign m0_tlast        = div_dout_tlast;
  assign m1_tlast        = div_dout_tlast;
  assign pop_s           = div_dout_tvalid & div_dout_tready;

  assign inflight = count_r;
  assign err      = err_r;

  // Tag FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Tag FIFO storage: owner id of every issued operation.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < DEPTH; i++) tag_mem_r[i] <= 1'b0;
    end else if (push_s) begin
      tag_mem_r[wr_ptr_r] <= gnt_id_s;
    end
  end

  // Arbitration history and packet lock, updated on each issue handshake.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      last_r    <= 1'b1;
      lock_r    <= 1'b0;
      lock_id_r <= 1'b0;
    end else if (push_s) begin
      last_r <= gnt_id_s;
      if (sel_last_s) begin
        lock_r <= 1'b0;
      end else if (PKT_LOCK) begin
        lock_r    <= 1'b1;
        lock_id_r <= gnt_id_s;
      end
    end
  end

  // Sticky error: a divider result showed up with nothing outstanding.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      err_r <= 1'b0;
    end else if (div_dout_tvalid && empty_s) begin
      err_r <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_divider_arbiter.sv
// Self-checking bench for axi_divider_arbiter with a behavioural divider
// model of fixed latency and per-requester result scoreboards.
module tb_axi_divider_arbiter;

  localparam int W     = 24;
  localparam int DEPTH = 8;
  localparam int LAT   = 3;
  localparam int IW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic aresetn;
  always #5 clk = ~clk;

  logic [W-1:0]   s0_dividend_tdata, s0_divisor_tdata, s1_dividend_tdata, s1_divisor_tdata;
  logic           s0_tlast, s0_tvalid, s0_tready, s1_tlast, s1_tvalid, s1_tready;
  logic [W-1:0]   div_dividend_tdata, div_divisor_tdata;
  logic           div_tlast, div_tvalid, div_tready;
  logic [2*W-1:0] div_dout_tdata;
  logic           div_dout_tlast, div_dout_tvalid, div_dout_tready;
  logic [2*W-1:0] m0_tdata, m1_tdata;
  logic           m0_tlast, m0_tvalid, m0_tready, m1_tlast, m1_tvalid, m1_tready;
  logic [IW-1:0]  inflight;
  logic           err;

  axi_divider_arbiter #(.W(W), .DEPTH(DEPTH), .PKT_LOCK(1'b1)) dut (
    .clk(clk), .aresetn(aresetn),
    .s0_dividend_tdata(s0_dividend_tdata), .s0_divisor_tdata(s0_divisor_tdata),
    .s0_tlast(s0_tlast), .s0_tvalid(s0_tvalid), .s0_tready(s0_tready),
    .s1_dividend_tdata(s1_dividend_tdata), .s1_divisor_tdata(s1_divisor_tdata),
    .s1_tlast(s1_tlast), .s1_tvalid(s1_tvalid), .s1_tready(s1_tready),
    .div_dividend_tdata(div_dividend_tdata), .div_divisor_tdata(div_divisor_tdata),
    .div_tlast(div_tlast), .div_tvalid(div_tvalid), .div_tready(div_tready),
    .div_dout_tdata(div_dout_tdata), .div_dout_tlast(div_dout_tlast),
    .div_dout_tvalid(div_dout_tvalid), .div_dout_tready(div_dout_tready),
    .m0_tdata(m0_tdata), .m0_tlast(m0_tlast), .m0_tvalid(m0_tvalid), .m0_tready(m0_tready),
    .m1_tdata(m1_tdata), .m1_tlast(m1_tlast), .m1_tvalid(m1_tvalid), .m1_tready(m1_tready),
    .inflight(inflight), .err(err)
  );

  typedef struct { logic [W-1:0] dd; logic [W-1:0] dv; logic tl; } beat_t;
  typedef struct { logic [2*W-1:0] d; logic tl; } res_t;
  typedef struct { logic [2*W-1:0] d; logic tl; int stamp; } dm_t;

  beat_t srcq0[$], srcq1[$];
  res_t  expq0[$], expq1[$];
  dm_t   dm_q[$];
  int    iss_log[$];
  logic [2*W-1:0] m0_log[$];

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  logic en0, en1, m0_rdy, m1_rdy, div_rdy, inj, seen_m1;
  logic samp_s0_rdy, samp_s1_rdy, samp_ddr, samp_m0v, samp_m1v;
  logic [IW-1:0] samp_infl;

  // Divider reference: signed quotient in the upper half, remainder below.
  function automatic logic [2*W-1:0] div_fn(input logic [W-1:0] a, input logic [W-1:0] b);
    int sa, sb, q, r;
    logic [W-1:0] qv, rv;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sb == 0) return {{W{1'b1}}, {W{1'b0}}};
    q = sa / sb;
    r = sa % sb;
    qv = q[W-1:0];
    rv = r[W-1:0];
    return {qv, rv};
  endfunction

  function automatic beat_t mk(input int a, input int b, input logic tl);
    beat_t bt;
    bt.dd = a[W-1:0];
    bt.dv = b[W-1:0];
    bt.tl = tl;
    return bt;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock cycle: drive at negedge, settle, account for handshakes taken at next posedge.
  task automatic step();
    beat_t b;
    res_t  e;
    dm_t   dm;
    @(negedge clk);
    if (en0 && srcq0.size() > 0) begin
      s0_tvalid = 1'b1; s0_dividend_tdata = srcq0[0].dd; s0_divisor_tdata = srcq0[0].dv; s0_tlast = srcq0[0].tl;
    end else begin
      s0_tvalid = 1'b0; s0_dividend_tdata = '0; s0_divisor_tdata = '0; s0_tlast = 1'b0;
    end
    if (en1 && srcq1.size() > 0) begin
      s1_tvalid = 1'b1; s1_dividend_tdata = srcq1[0].dd; s1_divisor_tdata = srcq1[0].dv; s1_tlast = srcq1[0].tl;
    end else begin
      s1_tvalid = 1'b0; s1_dividend_tdata = '0; s1_divisor_tdata = '0; s1_tlast = 1'b0;
    end
    div_tready = div_rdy;
    m0_tready  = m0_rdy;
    m1_tready  = m1_rdy;
    if (inj) begin
      div_dout_tvalid = 1'b1; div_dout_tdata = 48'hDEAD0000BEEF; div_dout_tlast = 1'b0;
    end else if (dm_q.size() > 0 && dm_q[0].stamp + LAT <= cyc) begin
      div_dout_tvalid = 1'b1; div_dout_tdata = dm_q[0].d; div_dout_tlast = dm_q[0].tl;
    end else begin
      div_dout_tvalid = 1'b0; div_dout_tdata = '0; div_dout_tlast = 1'b0;
    end
    #1;
    samp_s0_rdy = s0_tready; samp_s1_rdy = s1_tready; samp_ddr = div_dout_tready;
    samp_m0v = m0_tvalid; samp_m1v = m1_tvalid; samp_infl = inflight;
    if (m1_tvalid) seen_m1 = 1'b1;
    if (s0_tvalid && s0_tready) begin
      b = srcq0.pop_front();
      chk("issue0", {13'd0, div_tvalid, div_dividend_tdata, div_divisor_tdata, div_tlast}, {13'd0, 1'b1, b.dd, b.dv, b.tl});
      e.d = div_fn(b.dd, b.dv); e.tl = b.tl;
      expq0.push_back(e);
      iss_log.push_back(0);
    end
    if (s1_tvalid && s1_tready) begin
      b = srcq1.pop_front();
      chk("issue1", {13'd0, div_tvalid, div_dividend_tdata, div_divisor_tdata, div_tlast}, {13'd0, 1'b1, b.dd, b.dv, b.tl});
      e.d = div_fn(b.dd, b.dv); e.tl = b.tl;
      expq1.push_back(e);
      iss_log.push_back(1);
    end
    if (div_tvalid && div_tready) begin
      dm.d = div_fn(div_dividend_tdata, div_divisor_tdata); dm.tl = div_tlast; dm.stamp = cyc;
      dm_q.push_back(dm);
    end
    if (div_dout_tvalid && div_dout_tready && !inj) void'(dm_q.pop_front());
    if (m0_tvalid && m0_tready) begin
      if (expq0.size() == 0) chk("m0_extra", {63'd0, m0_tvalid}, 64'd0);
      else begin
        e = expq0.pop_front();
        chk("m0_result", {15'd0, m0_tlast, m0_tdata}, {15'd0, e.tl, e.d});
        m0_log.push_back(m0_tdata);
      end
    end
    if (m1_tvalid && m1_tready) begin
      if (expq1.size() == 0) chk("m1_extra", {63'd0, m1_tvalid}, 64'd0);
      else begin
        e = expq1.pop_front();
        chk("m1_result", {15'd0, m1_tlast, m1_tdata}, {15'd0, e.tl, e.d});
      end
    end
    cyc++;
  endtask

  task automatic drain(input string tag, input int bound);
    int n = 0;
    while ((srcq0.size() + srcq1.size() + expq0.size() + expq1.size() + dm_q.size()) > 0 && n < bound) begin
      step();
      n++;
    end
    chk(tag, 64'(srcq0.size() + srcq1.size() + expq0.size() + expq1.size() + dm_q.size()), 64'd0);
  endtask

  task automatic chk_order(input string tag, input int n, input int pat[]);
    for (int i = 0; i < n; i++)
      chk(tag, (iss_log.size() > i) ? 64'(iss_log[i]) : 64'hFF, 64'(pat[i]));
  endtask

  // Asynchronous reset pulse; the divider model is reset along with the block.
  task automatic apply_reset(input string tag);
    #2 aresetn = 1'b0;
    srcq0.delete(); srcq1.delete(); expq0.delete(); expq1.delete(); dm_q.delete();
    #1;
    chk({tag, "_inflight"}, 64'(inflight), 64'd0);
    chk({tag, "_err"}, {63'd0, err}, 64'd0);
    chk({tag, "_mvalid"}, {62'd0, m0_tvalid, m1_tvalid}, 64'd0);
    chk({tag, "_dout_rdy"}, {63'd0, div_dout_tready}, 64'd0);
    s0_tvalid = 1'b0; s1_tvalid = 1'b0; div_dout_tvalid = 1'b0; inj = 1'b0;
    @(negedge clk);
    #2 aresetn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn = 1'b0;
    en0 = 1'b1; en1 = 1'b1; m0_rdy = 1'b1; m1_rdy = 1'b1; div_rdy = 1'b1; inj = 1'b0; seen_m1 = 1'b0;
    s0_tvalid = 1'b0; s0_tlast = 1'b0; s0_dividend_tdata = '0; s0_divisor_tdata = '0;
    s1_tvalid = 1'b0; s1_tlast = 1'b0; s1_dividend_tdata = '0; s1_divisor_tdata = '0;
    div_tready = 1'b0; div_dout_tvalid = 1'b0; div_dout_tdata = '0; div_dout_tlast = 1'b0;
    m0_tready = 1'b0; m1_tready = 1'b0;
    #1;
    chk("rst_inflight", 64'(inflight), 64'd0);
    chk("rst_err", {63'd0, err}, 64'd0);
    chk("rst_outs", {60'd0, div_tvalid, div_dout_tready, m0_tvalid, m1_tvalid}, 64'd0);
    @(negedge clk);
    #2 aresetn = 1'b1;

    // Single-beat packets on both sides: strict alternation starting with 0.
    srcq0.push_back(mk(100, 4, 1'b1));  srcq0.push_back(mk(200, 8, 1'b1));
    srcq0.push_back(mk(-90, 3, 1'b1));  srcq0.push_back(mk(7, 7, 1'b1));
    srcq1.push_back(mk(300, 5, 1'b1));  srcq1.push_back(mk(64, 16, 1'b1));
    srcq1.push_back(mk(1000, 7, 1'b1)); srcq1.push_back(mk(45, -9, 1'b1));
    iss_log.delete(); m0_log.delete();
    drain("t1_drain", 60);
    chk_order("t1_order", 8, '{0, 1, 0, 1, 0, 1, 0, 1});
    chk("t1_m0_first", (m0_log.size() > 0) ? 64'(m0_log[0]) : 64'hFFFF, {16'd0, 24'd25, 24'd0});

    // Packet lock: s0 4-beat packet issues contiguously, s1 follows.
    en1 = 1'b0;
    srcq0.push_back(mk(12, 3, 1'b0)); srcq0.push_back(mk(81, 9, 1'b0));
    srcq0.push_back(mk(50, 2, 1'b0)); srcq0.push_back(mk(99, 11, 1'b1));
    srcq1.push_back(mk(36, 6, 1'b1)); srcq1.push_back(mk(77, 7, 1'b1));
    iss_log.delete();
    step();
    en1 = 1'b1;
    drain("t2_drain", 60);
    chk_order("t2_order", 6, '{0, 0, 0, 0, 1, 1});

    // Divider stall, then head-of-line blocking behind a stalled m0.
    m0_rdy = 1'b0; div_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      srcq0.push_back(mk(1000 + i, 10, 1'b1));
      srcq1.push_back(mk(2000 + i, 20, 1'b1));
    end
    repeat (20) step();
    chk("t3_stall_inflight", 64'(inflight), 64'd0);
    chk("t3_stall_ready", {62'd0, samp_s0_rdy, samp_s1_rdy}, 64'd0);
    div_rdy = 1'b1; seen_m1 = 1'b0;
    repeat (14) step();
    chk("t3_inflight", 64'(inflight), 64'(DEPTH));
    chk("t3_m1_blocked", {63'd0, seen_m1}, 64'd0);
    chk("t3_m0_waiting", {63'd0, m0_tvalid}, 64'd1);
    m0_rdy = 1'b1;
    drain("t3_drain", 60);

    // Fill to DEPTH, release one result, issue resumes a cycle later.
    m0_rdy = 1'b0;
    for (int i = 0; i < 10; i++) srcq0.push_back(mk(40 * (i + 1), 4, 1'b1));
    repeat (14) step();
    chk("t4_full_inflight", 64'(inflight), 64'(DEPTH));
    chk("t4_full_ready", {63'd0, samp_s0_rdy}, 64'd0);
    chk("t4_pending", 64'(srcq0.size()), 64'd2);
    m0_rdy = 1'b1;
    step();
    chk("t4_pop_cycle", {59'd0, samp_s0_rdy, samp_infl}, {59'd0, 1'b0, 4'(DEPTH)});
    m0_rdy = 1'b0;
    step();
    chk("t4_reissue", {59'd0, samp_s0_rdy, samp_infl}, {59'd0, 1'b1, 4'(DEPTH - 1)});
    step();
    chk("t4_refull", 64'(samp_infl), 64'(DEPTH));
    m0_rdy = 1'b1;
    drain("t4_drain", 60);

    // Spurious divider output with empty FIFO sets sticky err.
    inj = 1'b1;
    step();
    chk("t5_inj_outs", {61'd0, samp_ddr, samp_m0v, samp_m1v}, 64'd0);
    inj = 1'b0;
    step();
    chk("t5_err_set", {63'd0, err}, 64'd1);
    repeat (3) step();
    chk("t5_err_sticky", {63'd0, err}, 64'd1);
    m0_rdy = 1'b0;
    srcq0.push_back(mk(30, 3, 1'b1)); srcq0.push_back(mk(60, 3, 1'b1));
    repeat (6) step();
    chk("t5_pre_rst", {59'd0, m0_tvalid, inflight}, {59'd0, 1'b1, 4'd2});
    apply_reset("t5_rst");
    m0_rdy = 1'b1;

    // Reset in the middle of a locked s1 packet.
    en0 = 1'b0;
    srcq1.push_back(mk(10, 2, 1'b0)); srcq1.push_back(mk(20, 2, 1'b1));
    iss_log.delete();
    step();
    chk_order("t6_pre", 1, '{1});
    apply_reset("t6_rst");
    en0 = 1'b1;
    srcq0.push_back(mk(15, 5, 1'b1)); srcq0.push_back(mk(16, 4, 1'b1));
    srcq1.push_back(mk(18, 3, 1'b1)); srcq1.push_back(mk(21, 7, 1'b1));
    iss_log.delete();
    drain("t6_drain", 60);
    chk_order("t6_order", 4, '{0, 1, 0, 1});
    chk("t6_err", {63'd0, err}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
